// File: rtl/pwm_multi_channel.sv
// rtl/pwm_multi_channel.sv - multi-channel PWM generator with shared counter and shadowed settings
module pwm_multi_channel #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [WIDTH-1:0]          period,
  input  logic                      center_mode,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic [CHANNELS-1:0]       invert,
  input  logic                      update,
  output logic                      update_pending,
  output logic                      period_start,
  output logic [CHANNELS-1:0]       pwm_out
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // staging set, written by the update strobe
  logic [WIDTH-1:0]          stg_period;
  logic                      stg_mode;
  logic [CHANNELS*WIDTH-1:0] stg_duty;

  // active set, used by the counter and comparators
  logic [WIDTH-1:0]          act_period;
  logic                      act_mode;
  logic [CHANNELS*WIDTH-1:0] act_duty;

  // shared counter; dir_down = 1 while a center-aligned period counts down
  logic [WIDTH-1:0]          cnt;
  logic                      dir_down;

  logic [WIDTH-1:0]          cnt_next;
  logic                      dir_next;
  logic                      boundary;
  logic                      transfer;
  logic [CHANNELS-1:0]       raw;

  // successor count and direction for the active mode
  always_comb begin
    cnt_next = '0;
    dir_next = 1'b0;
    if (!act_mode) begin
      if (cnt >= act_period) cnt_next = '0;
      else                   cnt_next = cnt + ONE;
    end else if (!dir_down) begin
      if (cnt >= act_period) begin
        cnt_next = (act_period == '0) ? '0 : act_period - ONE;
        dir_next = 1'b1;
      end else begin
        cnt_next = cnt + ONE;
      end
    end else begin
      cnt_next = (cnt == '0) ? '0 : cnt - ONE;
      dir_next = 1'b1;
    end
    // reaching zero always restarts the period counting up
    if (cnt_next == '0) dir_next = 1'b0;
  end

  assign boundary = (cnt_next == '0);
  // while idle there is no period to finish, so pending values move over at once
  assign transfer = update_pending && (!enable || boundary);

  // per-channel compare of the live count against the active duty
  always_comb begin
    raw = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      raw[c] = (cnt < act_duty[c*WIDTH +: WIDTH]);
    end
  end

  // double-buffered settings: staging captures on update, active loads on transfer
  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      stg_period     <= '1;
      stg_mode       <= 1'b0;
      stg_duty       <= '0;
      act_period     <= '1;
      act_mode       <= 1'b0;
      act_duty       <= '0;
      update_pending <= 1'b0;
    end else begin
      if (transfer) begin
        act_period <= stg_period;
        act_mode   <= stg_mode;
        act_duty   <= stg_duty;
      end
      if (update) begin
        stg_period <= period;
        stg_mode   <= center_mode;
        stg_duty   <= duty;
      end
      // a strobe on the transfer cycle keeps the flag set for the newer values
      if (update)        update_pending <= 1'b1;
      else if (transfer) update_pending <= 1'b0;
    end
  end

  // period counter; held at zero counting up while idle
  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      cnt      <= '0;
      dir_down <= 1'b0;
    end else if (!enable) begin
      cnt      <= '0;
      dir_down <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      dir_down <= dir_next;
    end
  end

  // registered outputs, one cycle behind the count
  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      pwm_out      <= '0;
      period_start <= 1'b0;
    end else if (!enable) begin
      pwm_out      <= invert;
      period_start <= 1'b0;
    end else begin
      pwm_out      <= raw ^ invert;
      period_start <= (cnt == '0);
    end
  end

endmodule

// File: doc/pwm_multi_channel.md
# pwm_multi_channel

Parametrised multi-channel PWM generator that supersedes the single-channel duty-cycle generator. All channels share one period counter. The block supports edge-aligned and center-aligned counting, double-buffered (shadow) period/duty/mode registers that take effect only at period boundaries, and per-channel output polarity. It sits between the processor-facing register block and the motor/LED drive pins.

## Interface
- CHANNELS, 4, number of PWM outputs
- WIDTH, 8, width of counter, period and each duty value
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-high reset (despite the name)
- enable  in  1  run counter; 0 = idle
- period  in  WIDTH  period value P, staged on update
- center_mode  in  1  0 = edge-aligned, 1 = center-aligned; staged on update
- duty  in  CHANNELS*WIDTH  duty D[c] in bits [c*WIDTH +: WIDTH]; staged on update
- invert  in  CHANNELS  per-channel output polarity, applied live (not staged)
- update  in  1  single-cycle strobe: capture period/center_mode/duty into staging
- update_pending  out  1  staging holds values not yet active
- period_start  out  1  one-cycle pulse, first cycle of each period
- pwm_out  out  CHANNELS  PWM outputs

## Operation
- Registers:
  - staging set: stg_period, stg_mode, stg_duty[c].
  - active set: act_period, act_mode, act_duty[c].
  - counter cnt (WIDTH bits), direction dir (up/down).
- Reset values:
  - act_period = 2^WIDTH-1, act_mode = edge, act_duty = 0; staging identical.
  - cnt = 0, dir = up.
  - pwm_out = 0, period_start = 0, update_pending = 0.
- Update:
  - update=1 loads staging from the inputs and sets update_pending.
  - Repeated updates before transfer: last one wins.
- Transfer:
  - Occurs on the boundary cycle if update_pending=1. Active set ← staging, update_pending ← 0.
  - If update=1 on the same boundary cycle: the old staging transfers, the new inputs load into staging, and update_pending stays 1.
- Boundary cycle: the cycle whose successor count is 0.
- Edge mode:
  - cnt runs 0..P, then wraps to 0. Period = P+1 cycles.
  - raw[c] = (cnt < D[c]).
  - D=0 gives constant low. D>P gives constant high.
- Center mode:
  - cnt goes up 0..P, dir flips at P, then down P-1..1, then 0 with dir=up. Period = 2P cycles.
  - raw[c] = (cnt < D[c]), giving a pulse centred on cnt=0.
  - High time: 2D-1 cycles for 1≤D≤P; 0 for D=0; 2P (constant high) for D>P.
- P=0 (both modes): cnt stays 0, every cycle is a boundary, period = 1 cycle.
- Mode change takes effect only via transfer. After a transfer, cnt restarts at 0 with dir=up.
- enable=0:
  - cnt ← 0, dir ← up, pwm_out ← invert, period_start ← 0.
  - A pending staging set transfers on the next clock, without waiting for a boundary.
- Width rules:
  - All compares are unsigned WIDTH-bit.
  - cnt never exceeds act_period. No overflow is possible because P ≤ 2^WIDTH-1.

## Timing
- pwm_out and period_start are registered, with 1-cycle latency from cnt:
  - pwm_out[c](t+1) = raw[c](t) XOR invert[c](t).
  - period_start(t+1) = enable(t) AND cnt(t)==0.
- First enabled cycle after enable rises: cnt=0. period_start pulses on the next cycle.
- Values transferred at boundary t are used by the count at t+1, so the new period's first pwm_out sample appears at t+2.
- update_pending rises the cycle after the update strobe. It falls the cycle after the transfer.
- Reset asserted mid-operation: all registers return to reset values immediately (asynchronous). The first edge after release with enable=1 starts at cnt=0.

## Test plan
- Edge full-range check:
  - Stimulus: WIDTH=8, P=255, edge mode, D={0,64,128,255}, invert=0, enable=1.
  - Required: over each 256-cycle period, high counts are 0/64/128/255; period_start every 256 cycles.
- Edge saturation:
  - Stimulus: P=99, D={150,100,99,1}.
  - Required: ch0 and ch1 constant high; ch2 high 99 of 100 cycles; ch3 high 1 of 100 cycles; period_start every 100 cycles.
- Shadow update mid-period:
  - Stimulus: P=255, D0=200; at cnt=40 strobe update with D0=10, P=49.
  - Required: the current period completes with 200 high cycles and update_pending=1; the next period is 50 cycles with 10 high; pending clears at the boundary.
- Center mode:
  - Stimulus: P=100, D0=25, D1=0, D2=101.
  - Required: period 200 cycles; ch0 high 49 cycles, centred on period_start; ch1 always low; ch2 always high.
- Disable, invert and update-while-idle:
  - Stimulus: enable=0, invert=4'b0101; then update with D0=5.
  - Required: pwm_out=4'b0101 constantly; update_pending high for exactly 1 cycle.
  - Then: after enable=1, ch0 output low for 5 cycles per period (inverted).
- Reset mid-period and same-cycle update:
  - Stimulus: assert reset_n while pwm_out[0]=1.
  - Required: all outputs 0 immediately, act_period=255 after release.
  - Stimulus: update on a boundary cycle.
  - Required: update_pending stays 1 and the new values apply one period later.
